// File: rtl/uart_core.sv
// uart_core: full-duplex UART, 16x oversampling, programmable baud divider.
//
// Frame: start, 5..8 data bits LSB first, optional even parity, 1 or 2 stop bits.
// TX takes bytes from a valid/ready source. RX delivers bytes to a valid/ready sink.
//
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   cfg_en_i              core enable; low forces TX/RX idle and clears rx_vld_o
//   cfg_div_i[11:0]       oversample tick every cfg_div_i+1 clocks
//   cfg_bits_i[1:0]       data bits: 00=5, 01=6, 10=7, 11=8
//   cfg_parity_en_i       even parity bit present
//   cfg_stop_bits_i       0=1 stop bit, 1=2 stop bits (TX only)
//   tx_o, tx_busy_o       serial output (idle high), frame in progress
//   tx_data_i, tx_vld_i, tx_rdy_o   transmit byte handshake
//   rx_i                  serial input
//   rx_data_o, rx_vld_o, rx_rdy_i   receive byte handshake
//
// Handshake rule (both sides): a byte moves on a rising clock edge where
// valid and ready are both high. Valid, once raised, holds with stable data
// until that edge. tx_rdy_o is combinational; all other outputs are flops.
//
// Build option: define UART_RX_SYNC_EN to put a 2-flop synchronizer
// (reset to 1) on rx_i. Without it rx_i must already be synchronous.

module uart_core (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        cfg_en_i,
    input  logic [11:0] cfg_div_i,
    input  logic [1:0]  cfg_bits_i,
    input  logic        cfg_parity_en_i,
    input  logic        cfg_stop_bits_i,
    output logic        tx_o,
    output logic        tx_busy_o,
    input  logic [7:0]  tx_data_i,
    input  logic        tx_vld_i,
    output logic        tx_rdy_o,
    input  logic        rx_i,
    output logic [7:0]  rx_data_o,
    output logic        rx_vld_o,
    input  logic        rx_rdy_i
);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_e;

    // ---------------- RX input conditioning ----------------
    logic rx_s;
`ifdef UART_RX_SYNC_EN
    logic [1:0] rx_sync_q, rx_sync_d;
    always_comb rx_sync_d = {rx_sync_q[0], rx_i};
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) rx_sync_q <= 2'b11;
        else          rx_sync_q <= rx_sync_d;
    end
    assign rx_s = rx_sync_q[1];
`else
    assign rx_s = rx_i;
`endif

    // ---------------- TX ----------------
    // TX keeps its own divider phase, restarted on accept, so every frame
    // lasts exactly (1+N+P+S)*16*(div+1) clocks from the accepting edge.
    tx_state_e   tx_state_q, tx_state_d;
    logic [11:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [3:0]  tx_tick_q, tx_tick_d;
    logic [2:0]  tx_idx_q, tx_idx_d;
    logic [7:0]  tx_sh_q, tx_sh_d;
    logic [1:0]  tx_bits_q, tx_bits_d;
    logic        tx_par_en_q, tx_par_en_d, tx_par_q, tx_par_d;
    logic        tx_stop2_q, tx_stop2_d;
    logic        tx_o_q, tx_o_d, tx_busy_q, tx_busy_d;
    logic        tx_baud, tx_bit_end;
    logic [7:0]  tx_mask;

    assign tx_rdy_o   = cfg_en_i && (tx_state_q == TX_IDLE);
    assign tx_baud    = (tx_cnt_q == tx_div_q);
    assign tx_bit_end = tx_baud && (tx_tick_q == 4'd15);
    assign tx_mask    = 8'hFF >> (2'd3 - cfg_bits_i);

    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_div_d    = tx_div_q;
        tx_tick_d   = tx_tick_q;
        tx_idx_d    = tx_idx_q;
        tx_sh_d     = tx_sh_q;
        tx_bits_d   = tx_bits_q;
        tx_par_en_d = tx_par_en_q;
        tx_par_d    = tx_par_q;
        tx_stop2_d  = tx_stop2_q;
        tx_o_d      = tx_o_q;
        tx_busy_d   = tx_busy_q;
        if (!cfg_en_i) begin
            tx_state_d = TX_IDLE;
            tx_cnt_d   = 12'd0;
            tx_tick_d  = 4'd0;
            tx_o_d     = 1'b1;
            tx_busy_d  = 1'b0;
        end else if (tx_state_q == TX_IDLE) begin
            if (tx_vld_i) begin
                tx_state_d  = TX_START;
                tx_cnt_d    = 12'd0;
                tx_tick_d   = 4'd0;
                tx_div_d    = cfg_div_i;
                tx_bits_d   = cfg_bits_i;
                tx_par_en_d = cfg_parity_en_i;
                tx_stop2_d  = cfg_stop_bits_i;
                tx_sh_d     = tx_data_i & tx_mask;
                tx_par_d    = ^(tx_data_i & tx_mask);
                tx_o_d      = 1'b0;
                tx_busy_d   = 1'b1;
            end
        end else begin
            tx_cnt_d = tx_baud ? 12'd0 : tx_cnt_q + 12'd1;
            if (tx_baud) tx_tick_d = tx_tick_q + 4'd1;
            if (tx_bit_end) begin
                case (tx_state_q)
                    TX_START: begin
                        tx_state_d = TX_DATA;
                        tx_idx_d   = 3'd0;
                        tx_o_d     = tx_sh_q[0];
                    end
                    TX_DATA: begin
                        // Last data bit index is N-1 = bits+4 = {1, bits}.
                        if (tx_idx_q == {1'b1, tx_bits_q}) begin
                            tx_state_d = tx_par_en_q ? TX_PARITY : TX_STOP1;
                            tx_o_d     = tx_par_en_q ? tx_par_q : 1'b1;
                        end else begin
                            tx_idx_d = tx_idx_q + 3'd1;
                            tx_sh_d  = tx_sh_q >> 1;
                            tx_o_d   = tx_sh_q[1];
                        end
                    end
                    TX_PARITY: begin
                        tx_state_d = TX_STOP1;
                        tx_o_d     = 1'b1;
                    end
                    TX_STOP1: begin
                        tx_state_d = tx_stop2_q ? TX_STOP2 : TX_IDLE;
                        tx_busy_d  = tx_stop2_q;
                    end
                    default: begin
                        tx_state_d = TX_IDLE;
                        tx_busy_d  = 1'b0;
                    end
                endcase
            end
        end
    end

    // ---------------- RX ----------------
    // Divider phase restarts at start-bit detection; tick 7 of each bit
    // (the 8th oversample tick) is the mid-bit sample point.
    rx_state_e   rx_state_q, rx_state_d;
    logic [11:0] rx_cnt_q, rx_cnt_d;
    logic [3:0]  rx_tick_q, rx_tick_d;
    logic [2:0]  rx_idx_q, rx_idx_d;
    logic [7:0]  rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
    logic        rx_par_q, rx_par_d, rx_vld_q, rx_vld_d;
    logic        rx_baud, rx_mid, rx_end, rx_good;

    assign rx_baud = (rx_cnt_q == cfg_div_i);
    assign rx_mid  = rx_baud && (rx_tick_q == 4'd7);
    assign rx_end  = rx_baud && (rx_tick_q == 4'd15);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_tick_d  = rx_tick_q;
        rx_idx_d   = rx_idx_q;
        rx_sh_d    = rx_sh_q;
        rx_par_d   = rx_par_q;
        rx_data_d  = rx_data_q;
        rx_vld_d   = rx_vld_q;
        rx_good    = 1'b0;
        if (!cfg_en_i) begin
            rx_state_d = RX_IDLE;
            rx_cnt_d   = 12'd0;
            rx_tick_d  = 4'd0;
            rx_vld_d   = 1'b0;
        end else begin
            if (rx_state_q == RX_IDLE) begin
                if (!rx_s) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = 12'd0;
                    rx_tick_d  = 4'd0;
                end
            end else begin
                rx_cnt_d = rx_baud ? 12'd0 : rx_cnt_q + 12'd1;
                if (rx_baud) rx_tick_d = rx_tick_q + 4'd1;
                case (rx_state_q)
                    RX_START: begin
                        if (rx_mid && rx_s) begin
                            rx_state_d = RX_IDLE;  // glitch, not a start bit
                        end else if (rx_end) begin
                            rx_state_d = RX_DATA;
                            rx_idx_d   = 3'd0;
                            rx_sh_d    = 8'd0;
                            rx_par_d   = 1'b0;
                        end
                    end
                    RX_DATA: begin
                        if (rx_mid) begin
                            rx_sh_d[rx_idx_q] = rx_s;
                            rx_par_d          = rx_par_q ^ rx_s;
                        end else if (rx_end) begin
                            if (rx_idx_q == {1'b1, cfg_bits_i}) begin
                                rx_state_d = cfg_parity_en_i ? RX_PARITY : RX_STOP;
                                // Without a parity bit the running XOR is meaningless.
                                if (!cfg_parity_en_i) rx_par_d = 1'b0;
                            end else begin
                                rx_idx_d = rx_idx_q + 3'd1;
                            end
                        end
                    end
                    RX_PARITY: begin
                        if (rx_mid)      rx_par_d   = rx_par_q ^ rx_s;
                        else if (rx_end) rx_state_d = RX_STOP;
                    end
                    RX_STOP: begin
                        // Leave at mid stop bit so a following start edge is seen.
                        if (rx_mid) begin
                            rx_state_d = RX_IDLE;
                            rx_good    = rx_s && !rx_par_q;
                        end
                    end
                    default: rx_state_d = RX_IDLE;
                endcase
            end
            if (rx_vld_q && rx_rdy_i) rx_vld_d = 1'b0;
            // Overrun: an unconsumed byte is kept and the new one dropped.
            if (rx_good && (!rx_vld_q || rx_rdy_i)) begin
                rx_data_d = rx_sh_q;
                rx_vld_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= 12'd0;
            tx_div_q    <= 12'd0;
            tx_tick_q   <= 4'd0;
            tx_idx_q    <= 3'd0;
            tx_sh_q     <= 8'd0;
            tx_bits_q   <= 2'd0;
            tx_par_en_q <= 1'b0;
            tx_par_q    <= 1'b0;
            tx_stop2_q  <= 1'b0;
            tx_o_q      <= 1'b1;
            tx_busy_q   <= 1'b0;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= 12'd0;
            rx_tick_q   <= 4'd0;
            rx_idx_q    <= 3'd0;
            rx_sh_q     <= 8'd0;
            rx_par_q    <= 1'b0;
            rx_data_q   <= 8'd0;
            rx_vld_q    <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_div_q    <= tx_div_d;
            tx_tick_q   <= tx_tick_d;
            tx_idx_q    <= tx_idx_d;
            tx_sh_q     <= tx_sh_d;
            tx_bits_q   <= tx_bits_d;
            tx_par_en_q <= tx_par_en_d;
            tx_par_q    <= tx_par_d;
            tx_stop2_q  <= tx_stop2_d;
            tx_o_q      <= tx_o_d;
            tx_busy_q   <= tx_busy_d;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_tick_q   <= rx_tick_d;
            rx_idx_q    <= rx_idx_d;
            rx_sh_q     <= rx_sh_d;
            rx_par_q    <= rx_par_d;
            rx_data_q   <= rx_data_d;
            rx_vld_q    <= rx_vld_d;
        end
    end

    assign tx_o      = tx_o_q;
    assign tx_busy_o = tx_busy_q;
    assign rx_data_o = rx_data_q;
    assign rx_vld_o  = rx_vld_q;

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: bench for uart_core. Loopback tx_o -> rx_i or a bench-driven
// serial line; received bytes are checked against an expected queue.

module tb_uart_core;

    logic        clk = 1'b0;
    logic        rst_n, cfg_en, cfg_par, cfg_stop;
    logic [11:0] cfg_div;
    logic [1:0]  cfg_bits;
    logic        tx_o, tx_busy, tx_vld, tx_rdy;
    logic [7:0]  tx_data, rx_data;
    logic        rx_vld, rx_rdy, rx_drv, loop_en, rx_line;

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  exp_q[$];

    assign rx_line = loop_en ? tx_o : rx_drv;

    uart_core dut (
        .clk_i(clk), .rst_n_i(rst_n), .cfg_en_i(cfg_en), .cfg_div_i(cfg_div),
        .cfg_bits_i(cfg_bits), .cfg_parity_en_i(cfg_par), .cfg_stop_bits_i(cfg_stop),
        .tx_o(tx_o), .tx_busy_o(tx_busy), .tx_data_i(tx_data), .tx_vld_i(tx_vld),
        .tx_rdy_o(tx_rdy), .rx_i(rx_line), .rx_data_o(rx_data), .rx_vld_o(rx_vld),
        .rx_rdy_i(rx_rdy)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out", name);
    endtask

    // Scoreboard: every RX handshake pops one expected byte.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && rx_vld && rx_rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rx_unexpected: got %0h expected none", rx_data);
                end else begin
                    check("rx_byte", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_cfg(input logic [1:0] b, input logic p, input logic s);
        @(posedge clk);
        #1;
        cfg_bits = b;
        cfg_par  = p;
        cfg_stop = s;
    endtask

    // Returns #1 after the accepting edge.
    task automatic start_tx(input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!tx_rdy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!tx_rdy) timeout_fail("tx_rdy_wait");
        tx_data = d;
        tx_vld  = 1'b1;
        @(posedge clk);
        #1;
        tx_vld = 1'b0;
        check("tx_o_on_accept", {31'd0, tx_o}, 32'd0);
        check("tx_busy_on_accept", {31'd0, tx_busy}, 32'd1);
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (tx_busy && cyc < 5000);
        if (tx_busy) timeout_fail("tx_busy_wait");
    endtask

    // Bench-driven frame on rx_i: start, 8 data, parity p, stop s, then idle.
    task automatic drive_frame(input logic [7:0] d, input logic p, input logic s);
        logic [10:0] f;
        f = {s, p, d, 1'b0};
        @(posedge clk);
        #1;
        for (int i = 0; i < 11; i++) begin
            rx_drv = f[i];
            repeat (256) @(posedge clk);
            #1;
        end
        rx_drv = 1'b1;
        repeat (512) @(posedge clk);
        #1;
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [7:0] data;
        logic [1:0] bits;
        logic       par;
        logic       stop;
        logic [7:0] exp_rx;
        int         exp_len;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #1_200_000;
        $display("FAIL watchdog: simulation did not finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int         cyc;
        logic [7:0] r;
        int         exp_line[12];

        vecs[0] = '{8'h34, 2'b11, 1'b1, 1'b1, 8'h34, 12 * 256};
        vecs[1] = '{8'h23, 2'b11, 1'b1, 1'b1, 8'h23, 12 * 256};
        vecs[2] = '{8'hA3, 2'b11, 1'b1, 1'b1, 8'hA3, 12 * 256};
        vecs[3] = '{8'hA3, 2'b10, 1'b0, 1'b0, 8'h23, 9 * 256};
        vecs[4] = '{8'h1F, 2'b00, 1'b1, 1'b0, 8'h1F, 8 * 256};
        vecs[5] = '{8'hC6, 2'b01, 1'b0, 1'b1, 8'h06, 9 * 256};
        vecs[6] = '{8'hFF, 2'b11, 1'b1, 1'b0, 8'hFF, 11 * 256};
        for (int i = 7; i < 10; i++) begin
            r = 8'($urandom_range(0, 255));
            vecs[i] = '{r, 2'b11, 1'b1, 1'b0, r, 11 * 256};
        end
        exp_line = '{0, 0, 0, 1, 0, 1, 1, 0, 0, 1, 1, 1};

        // ---- reset ----
        rst_n = 1'b0; cfg_en = 1'b1; cfg_div = 12'd15; cfg_bits = 2'b11;
        cfg_par = 1'b1; cfg_stop = 1'b1; tx_data = 8'd0; tx_vld = 1'b0;
        rx_rdy = 1'b1; rx_drv = 1'b1; loop_en = 1'b1;
        #12;
        check("rst_tx_o", {31'd0, tx_o}, 32'd1);
        check("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
        check("rst_rx_vld", {31'd0, rx_vld}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_tx_rdy_en", {31'd0, tx_rdy}, 32'd1);
        cfg_en = 1'b0;
        #1;
        check("tx_rdy_disabled", {31'd0, tx_rdy}, 32'd0);
        cfg_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // ---- table-driven loopback frames ----
        for (int i = 0; i < 10; i++) begin
            set_cfg(vecs[i].bits, vecs[i].par, vecs[i].stop);
            exp_q.push_back(vecs[i].exp_rx);
            start_tx(vecs[i].data);
            wait_idle(cyc);
            check($sformatf("frame_len[%0d]", i), cyc, vecs[i].exp_len);
            repeat (20) @(posedge clk);
            #1;
            check($sformatf("rx_pending[%0d]", i), exp_q.size(), 0);
        end

        // ---- line probe of 0x34 at bit mid-points ----
        set_cfg(2'b11, 1'b1, 1'b1);
        exp_q.push_back(8'h34);
        start_tx(8'h34);
        for (int k = 0; k < 12; k++) begin
            repeat (k == 0 ? 128 : 256) @(posedge clk);
            #1;
            check($sformatf("line_bit[%0d]", k), {31'd0, tx_o}, exp_line[k]);
        end
        wait_idle(cyc);
        check("probe_frame_len", cyc + 128 + 11 * 256, 3072);
        repeat (20) @(posedge clk);
        #1;
        check("probe_rx_pending", exp_q.size(), 0);

        // ---- overrun: hold rx_rdy low across two frames ----
        rx_rdy = 1'b0;
        exp_q.push_back(8'h11);
        start_tx(8'h11);
        wait_idle(cyc);
        start_tx(8'h22);
        wait_idle(cyc);
        repeat (5) @(posedge clk);
        #1;
        check("overrun_vld_held", {31'd0, rx_vld}, 32'd1);
        check("overrun_data_kept", {24'd0, rx_data}, 32'h11);
        rx_rdy = 1'b1;
        @(posedge clk);
        #1;
        rx_rdy = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        check("overrun_vld_cleared", {31'd0, rx_vld}, 32'd0);
        check("overrun_rx_pending", exp_q.size(), 0);
        rx_rdy = 1'b1;

        // ---- injected bad frames, then a good one ----
        loop_en = 1'b0;
        drive_frame(8'h55, 1'b1, 1'b1);   // 0x55 has even weight: parity should be 0
        drive_frame(8'h55, 1'b0, 1'b0);   // stop bit low
        check("bad_frames_no_vld", {31'd0, rx_vld}, 32'd0);
        exp_q.push_back(8'h55);
        drive_frame(8'h55, 1'b0, 1'b1);
        check("good_after_bad", exp_q.size(), 0);
        check("good_after_bad_data", {24'd0, rx_data}, 32'h55);

        // ---- reset mid-frame ----
        loop_en = 1'b1;
        start_tx(8'hA5);
        repeat (1000) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_tx_o", {31'd0, tx_o}, 32'd1);
        check("midrst_tx_busy", {31'd0, tx_busy}, 32'd0);
        check("midrst_rx_vld", {31'd0, rx_vld}, 32'd0);
        check("midrst_rx_data", {24'd0, rx_data}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ---- 4-clock glitch must be a false start ----
        loop_en = 1'b0;
        rx_drv  = 1'b1;
        @(posedge clk);
        #1;
        rx_drv = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx_drv = 1'b1;
        repeat (3000) @(posedge clk);
        #1;
        check("glitch_no_vld", {31'd0, rx_vld}, 32'd0);
        exp_q.push_back(8'h5A);
        drive_frame(8'h5A, 1'b0, 1'b1);
        check("rx_after_glitch", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
